// File: rtl/park_pkg.sv
// Shared parking-controller types and default lot parameters.
package park_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_ENTERING = 2'd2,
    ST_PASSING  = 2'd3
  } park_state_t;

  localparam int unsigned PARK_SLOTS_DEF = 8;
  localparam int unsigned PARK_TMO_DEF   = 100;

endpackage

// File: rtl/park_tmo_timer.sv
// Entry watchdog: counts enabled cycles since the last clear and flags the
// final allowed cycle (count == TMO-1).
module park_tmo_timer
  import park_pkg::*;
#(
  parameter int unsigned TMO = PARK_TMO_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned TW = $clog2(TMO);

  logic [TW-1:0] cnt;

  // Holds at the terminal value so expired stays a decode of a stable count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != TW'(TMO - 1))) begin
      cnt <= cnt + TW'(1);
    end
  end

  assign expired = en && (cnt == TW'(TMO - 1));

endmodule

// File: rtl/park_occupancy_ctrl.sv
// Confirms vehicle entries through the gate, tracks lot occupancy against
// exit-lane events, and gates the barrier controller when the lot is full.
module park_occupancy_ctrl
  import park_pkg::*;
#(
  parameter  int unsigned SLOTS = PARK_SLOTS_DEF,
  parameter  int unsigned TMO   = PARK_TMO_DEF,
  localparam int unsigned CW    = $clog2(SLOTS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          gate,
  input  logic          fr_sens,
  input  logic          bk_sens,
  input  logic          ex_sens,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          entry_ok,
  output logic          pass_done,
  output logic          tmo_err
);

  park_state_t state, state_nxt;
  logic        expired;
  logic        done_c;
  logic        tmo_c;
  logic        ex_q1, ex_q2;
  logic        ex_edge;
  logic        dec_ok;

  // Watchdog runs only while an entry is in progress; idle holds it cleared.
  park_tmo_timer #(.TMO(TMO)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == ST_IDLE),
    .en      (state != ST_IDLE),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (expired) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     if (gate && !full) state_nxt = ST_ARMED;
        ST_ARMED:    if (fr_sens) state_nxt = ST_ENTERING;
        ST_ENTERING: begin
          if (bk_sens)       state_nxt = ST_PASSING;
          else if (!fr_sens) state_nxt = ST_IDLE;
        end
        ST_PASSING:  if (!fr_sens && !bk_sens) state_nxt = ST_IDLE;
        default:     state_nxt = ST_IDLE;
      endcase
    end
  end

  // Event strobes; a timeout pre-empts a completion in the same cycle.
  always_comb begin
    done_c = 1'b0;
    tmo_c  = 1'b0;
    if (expired) begin
      tmo_c = 1'b1;
    end else if ((state == ST_PASSING) && !fr_sens && !bk_sens) begin
      done_c = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_done <= 1'b0;
      tmo_err   <= 1'b0;
    end else begin
      pass_done <= done_c;
      tmo_err   <= tmo_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q1 <= 1'b0;
      ex_q2 <= 1'b0;
    end else begin
      ex_q1 <= ex_sens;
      ex_q2 <= ex_q1;
    end
  end

  assign ex_edge = ex_q1 && !ex_q2;
  assign dec_ok  = ex_edge && (count != '0);

  // Entry and exit in the same cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (done_c && !dec_ok) begin
      if (count != CW'(SLOTS)) count <= count + CW'(1);
    end else if (dec_ok && !done_c) begin
      count <= count - CW'(1);
    end
  end

  assign full     = (count == CW'(SLOTS));
  assign empty    = (count == '0);
  assign entry_ok = (state == ST_IDLE) && !full;

endmodule

// File: tb/tb_park_occupancy_ctrl.sv
// Directed bench for park_occupancy_ctrl with a cycle-level behavioural model.
module tb_park_occupancy_ctrl;

  localparam int unsigned SLOTS = 8;
  localparam int unsigned TMO   = 100;
  localparam int unsigned CW    = $clog2(SLOTS + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          gate = 1'b0, fr_sens = 1'b0, bk_sens = 1'b0, ex_sens = 1'b0;
  logic [CW-1:0] count;
  logic          full, empty, entry_ok, pass_done, tmo_err;

  int errors = 0;
  int checks = 0;
  int n_pass = 0;
  int n_tmo  = 0;

  park_occupancy_ctrl #(.SLOTS(SLOTS), .TMO(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .gate      (gate),
    .fr_sens   (fr_sens),
    .bk_sens   (bk_sens),
    .ex_sens   (ex_sens),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .entry_ok  (entry_ok),
    .pass_done (pass_done),
    .tmo_err   (tmo_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an entry is a busy window with an age and a progress
  // marker (front seen, back seen); occupancy is a plain integer.
  int m_count, m_age, m_prog, m_d1, m_d2;
  bit m_busy, m_pass, m_tmo;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_count = 0; m_age = 0; m_prog = 0; m_busy = 0;
      m_d1 = 0; m_d2 = 0; m_pass = 0; m_tmo = 0;
    end else begin
      bit done, tmo, edge_seen, dec;
      done = 0; tmo = 0;
      if (m_busy) begin
        if (m_age == TMO - 1) begin
          m_busy = 0; tmo = 1;
        end else begin
          m_age++;
          if (m_prog == 0) begin
            if (fr_sens) m_prog = 1;
          end else if (m_prog == 1) begin
            if (bk_sens) m_prog = 2;
            else if (!fr_sens) m_busy = 0;
          end else if (!fr_sens && !bk_sens) begin
            m_busy = 0; done = 1;
          end
        end
      end else if (gate && m_count < SLOTS) begin
        m_busy = 1; m_prog = 0; m_age = 0;
      end
      edge_seen = (m_d1 == 1) && (m_d2 == 0);
      m_d2 = m_d1;
      m_d1 = int'(ex_sens);
      dec = edge_seen && m_count > 0;
      if (done && !dec) m_count = (m_count < SLOTS) ? m_count + 1 : m_count;
      else if (dec && !done) m_count--;
      m_pass = done;
      m_tmo  = tmo;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("count",     int'(count),     m_count);
      check("full",      int'(full),      int'(m_count == SLOTS));
      check("empty",     int'(empty),     int'(m_count == 0));
      check("entry_ok",  int'(entry_ok),  int'(!m_busy && m_count < SLOTS));
      check("pass_done", int'(pass_done), int'(m_pass));
      check("tmo_err",   int'(tmo_err),   int'(m_tmo));
      n_pass += int'(pass_done);
      n_tmo  += int'(tmo_err);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Full entry; with_exit lines an exit edge up with the completion cycle.
  task automatic do_entry(input bit with_exit);
    gate = 1'b1; tick();
    gate = 1'b0; fr_sens = 1'b1; tick(2);
    bk_sens = 1'b1; tick();
    fr_sens = 1'b0;
    if (with_exit) ex_sens = 1'b1;
    tick();
    bk_sens = 1'b0; tick();
    ex_sens = 1'b0; tick(2);
  endtask

  task automatic do_exit();
    ex_sens = 1'b1; tick();
    ex_sens = 1'b0; tick(2);
  endtask

  initial begin
    int p0, t0, cyc;
    bit seen;
    tick(3);
    check("rst_count",    int'(count),    0);
    check("rst_empty",    int'(empty),    1);
    check("rst_full",     int'(full),     0);
    check("rst_entry_ok", int'(entry_ok), 1);
    rst = 1'b0;
    tick(2);

    do_entry(1'b0);
    check("first_count",    int'(count),    1);
    check("first_pass_cnt", n_pass,         1);
    check("first_entry_ok", int'(entry_ok), 1);

    repeat (7) do_entry(1'b0);
    check("fill_count",    int'(count),    8);
    check("fill_full",     int'(full),     1);
    check("fill_entry_ok", int'(entry_ok), 0);
    gate = 1'b1; tick(3); gate = 1'b0; tick();
    check("full_gate_count",    int'(count),    8);
    check("full_gate_entry_ok", int'(entry_ok), 0);

    repeat (5) do_exit();
    check("exit5_count", int'(count), 3);

    p0 = n_pass;
    do_entry(1'b1);
    check("simul_count", int'(count), 3);
    check("simul_pass",  n_pass - p0, 1);

    p0 = n_pass;
    gate = 1'b1; tick();
    gate = 1'b0; fr_sens = 1'b1; tick(2);
    fr_sens = 1'b0; tick(2);
    check("backout_count",    int'(count),    3);
    check("backout_pass",     n_pass - p0,    0);
    check("backout_entry_ok", int'(entry_ok), 1);

    t0 = n_tmo; cyc = 0; seen = 0;
    gate = 1'b1; tick();
    gate = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (tmo_err) begin seen = 1; break; end
      if (!entry_ok) cyc++;
      tick();
    end
    check("tmo_seen",   int'(seen), 1);
    check("tmo_cycles", cyc,        int'(TMO));
    tick(3);
    check("tmo_once",     n_tmo - t0,     1);
    check("tmo_count",    int'(count),    3);
    check("tmo_entry_ok", int'(entry_ok), 1);

    repeat (4) do_exit();
    check("drain_count", int'(count), 0);
    check("drain_empty", int'(empty), 1);

    do_entry(1'b0);
    gate = 1'b1; tick();
    gate = 1'b0; fr_sens = 1'b1; tick();
    bk_sens = 1'b1; tick(2);
    #2 rst = 1'b1;
    #1;
    check("arst_count",     int'(count),     0);
    check("arst_empty",     int'(empty),     1);
    check("arst_full",      int'(full),      0);
    check("arst_entry_ok",  int'(entry_ok),  1);
    check("arst_pass_done", int'(pass_done), 0);
    check("arst_tmo_err",   int'(tmo_err),   0);
    fr_sens = 1'b0; bk_sens = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(4);
    check("post_rst_count", int'(count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
